// File: rtl/tb_douta_map.sv
// -----------------------------------------------------------------------------
// tb_douta_map
//   Read-side counterpart of the temp-buffer (TB) write mapper. A start pulse
//   launches a burst of row reads from the TB read port. Returned rows pass
//   through the inverse lane mapping (POS / NEG / NEW) and are delivered to
//   either the CB write path or the non-linear unit over a valid/ready
//   handshake.
//
//   Optional feature macro: TB_DOUTA_RD_CNT_EN
//     When defined, the output rd_cnt counts rows accepted downstream in the
//     current job.
//
// Ports
//   clk, sys_rst_n        clock, asynchronous active-low reset
//   start                 one-cycle job request (only honoured in IDLE)
//   TB_douta_sel[2:0]     [2] destination (0 CB, 1 non-linear),
//                         [1:0] mode (00 IDLE, 01 POS, 10 NEG, 11 NEW)
//   l_k_0                 NEW-mode half select
//   base_addr, row_num    first TB row and number of rows to read
//   TB_enb, TB_addrb      TB read enable / address
//   TB_doutb              TB read data, RD_LAT cycles after TB_enb
//   out_rdy               downstream ready
//   CB_dina(_vld)         mapped row to CB
//   nl_din(_vld)          mapped row to non-linear unit
//   busy, done            job in progress / one-cycle completion pulse
//   rd_cnt                (TB_DOUTA_RD_CNT_EN only) rows accepted this job
// -----------------------------------------------------------------------------
module tb_douta_map #(
    parameter int X          = 4,
    parameter int L          = 4,
    parameter int RSA_DW     = 16,
    parameter int TB_AW      = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [2:0]            TB_douta_sel,
    input  logic                  l_k_0,
    input  logic [TB_AW-1:0]      base_addr,
    input  logic [TB_AW-1:0]      row_num,
    output logic                  TB_enb,
    output logic [TB_AW-1:0]      TB_addrb,
    input  logic [L*RSA_DW-1:0]   TB_doutb,
    input  logic                  out_rdy,
    output logic [L*RSA_DW-1:0]   CB_dina,
    output logic                  CB_dina_vld,
    output logic [L*RSA_DW-1:0]   nl_din,
    output logic                  nl_din_vld,
    output logic                  busy,
    output logic                  done
`ifdef TB_DOUTA_RD_CNT_EN
    ,
    output logic [TB_AW-1:0]      rd_cnt
`endif
);

    localparam int DW = L * RSA_DW;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    // Inverse lane mapping applied to each returned TB row.
    function automatic logic [DW-1:0] map_row(input logic [DW-1:0] row,
                                              input logic [1:0]    mode,
                                              input logic          lk0);
        logic [DW-1:0] res;
        res = row;
        case (mode)
            2'b10: begin
                for (int i = 0; i < X; i++)
                    res[i*RSA_DW +: RSA_DW] = row[(X-1-i)*RSA_DW +: RSA_DW];
            end
            2'b11: begin
                res = '0;
                res[0 +: 2*RSA_DW] = lk0 ? row[0 +: 2*RSA_DW]
                                         : row[2*RSA_DW +: 2*RSA_DW];
            end
            default: res = row;
        endcase
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              lk0_q, lk0_d;
    logic [TB_AW-1:0]  addr_q, addr_d;
    logic [TB_AW-1:0]  rem_q, rem_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_vld_q, out_vld_d;
    logic [DW-1:0]     out_data_q, out_data_d;

    logic [CW-1:0]     in_flight;
    logic              credit_ok, issue, push, fifo_empty;
    logic              out_load, pop, bypass, fifo_wr;
    logic [DW-1:0]     push_data;

    // ---- Issue stage: credit check and read launch ----
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++)
            in_flight = in_flight + CW'(pipe_q[i]);
    end

    // Credits cover reads still in the BRAM plus rows parked in the FIFO, so
    // every returning row is guaranteed a slot.
    assign credit_ok = (in_flight + cnt_q) < CW'(FIFO_DEPTH);
    assign issue     = (state_q == S_ISSUE) && credit_ok;

    // ---- Return stage: latency pipe tail marks valid TB_doutb ----
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    assign push       = pipe_q[RD_LAT-1];
    assign push_data  = map_row(TB_doutb, sel_q[1:0], lk0_q);
    assign fifo_empty = (cnt_q == '0);

    // ---- Buffer / output stage ----
    // A returning row skips the FIFO when it is empty and the output register
    // can load, which keeps the start-up latency at RD_LAT+1.
    assign out_load = !out_vld_q || out_rdy;
    assign pop      = out_load && !fifo_empty;
    assign bypass   = out_load && fifo_empty && push;
    assign fifo_wr  = push && !bypass;

    always_comb begin
        wr_ptr_d   = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d      = cnt_q + CW'(fifo_wr) - CW'(pop);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (out_load) begin
            out_vld_d = pop || bypass;
            if (pop)
                out_data_d = fifo_mem[rd_ptr_q];
            else if (bypass)
                out_data_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr_q] <= push_data;
    end

    // ---- Control FSM ----
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lk0_d   = lk0_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d  = TB_douta_sel;
                    lk0_d  = l_k_0;
                    addr_d = base_addr;
                    rem_d  = row_num;
                    if (row_num == '0 || TB_douta_sel[1:0] == 2'b00)
                        state_d = S_DONE;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + TB_AW'(1);
                    rem_d  = rem_q - TB_AW'(1);
                    if (rem_q == TB_AW'(1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Nothing in flight, nothing buffered, last row taken.
                if (in_flight == '0 && fifo_empty && (!out_vld_q || out_rdy))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            lk0_q      <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            lk0_q      <= lk0_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            pipe_q     <= pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign TB_enb      = issue;
    assign TB_addrb    = addr_q;
    assign CB_dina     = sel_q[2] ? '0 : out_data_q;
    assign CB_dina_vld = out_vld_q & ~sel_q[2];
    assign nl_din      = sel_q[2] ? out_data_q : '0;
    assign nl_din_vld  = out_vld_q & sel_q[2];
    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);

`ifdef TB_DOUTA_RD_CNT_EN
    logic [TB_AW-1:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (state_q == S_IDLE && start)
            rd_cnt_d = '0;
        else if (out_vld_q && out_rdy)
            rd_cnt_d = rd_cnt_q + TB_AW'(1);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            rd_cnt_q <= '0;
        else
            rd_cnt_q <= rd_cnt_d;
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_tb_douta_map.sv
// -----------------------------------------------------------------------------
// tb_tb_douta_map
//   Directed bench for tb_douta_map with a behavioural TB read port (RD_LAT
//   deep), an address scoreboard and a row scoreboard. Expected addresses and
//   rows are queued when a job is launched and popped as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_tb_douta_map;

    localparam int X          = 4;
    localparam int L          = 4;
    localparam int RSA_DW     = 16;
    localparam int TB_AW      = 8;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int DW         = L * RSA_DW;

    logic              clk = 1'b0;
    logic              sys_rst_n;
    logic              start;
    logic [2:0]        TB_douta_sel;
    logic              l_k_0;
    logic [TB_AW-1:0]  base_addr;
    logic [TB_AW-1:0]  row_num;
    logic              TB_enb;
    logic [TB_AW-1:0]  TB_addrb;
    logic [DW-1:0]     TB_doutb;
    logic              out_rdy;
    logic [DW-1:0]     CB_dina;
    logic              CB_dina_vld;
    logic [DW-1:0]     nl_din;
    logic              nl_din_vld;
    logic              busy;
    logic              done;
`ifdef TB_DOUTA_RD_CNT_EN
    logic [TB_AW-1:0]  rd_cnt;
`endif

    tb_douta_map #(
        .X(X), .L(L), .RSA_DW(RSA_DW), .TB_AW(TB_AW),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .start(start),
        .TB_douta_sel(TB_douta_sel), .l_k_0(l_k_0),
        .base_addr(base_addr), .row_num(row_num),
        .TB_enb(TB_enb), .TB_addrb(TB_addrb), .TB_doutb(TB_doutb),
        .out_rdy(out_rdy),
        .CB_dina(CB_dina), .CB_dina_vld(CB_dina_vld),
        .nl_din(nl_din), .nl_din_vld(nl_din_vld),
        .busy(busy), .done(done)
`ifdef TB_DOUTA_RD_CNT_EN
        , .rd_cnt(rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural TB read port: data appears RD_LAT cycles after TB_enb.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (TB_enb) rd_pipe[0] <= mem[TB_addrb];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign TB_doutb = rd_pipe[RD_LAT-1];

    int vectors = 0;
    int miscompares = 0;

    logic [TB_AW-1:0] exp_addr_q [$];
    logic [DW:0]      exp_q [$];     // {dest, row}
    int               enb_cyc [$];
    int               out_cyc [$];
    int               done_cnt = 0;
    int               done_base = 0;
    int               done_cyc = 0;
    int               start_cyc = 0;
    int               nl_vld_cycles = 0;
    int               cb_vld_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin : monitor
        logic [DW:0]   e;
        logic [DW-1:0] cur;
        logic [DW-1:0] other;
        if (sys_rst_n) begin
            cur   = CB_dina_vld ? CB_dina : nl_din;
            other = CB_dina_vld ? nl_din : CB_dina;
            if (TB_enb) begin
                enb_cyc.push_back(cyc);
                chk("addr_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                if (exp_addr_q.size() != 0)
                    chk("tb_addr", 64'(TB_addrb), 64'(exp_addr_q.pop_front()));
            end
            if (nl_din_vld) nl_vld_cycles++;
            if (CB_dina_vld) cb_vld_cycles++;
            if (prev_stall) begin
                chk("stall_vld", 64'(CB_dina_vld | nl_din_vld), 64'd1);
                chk("stall_data", cur, prev_data);
            end
            if ((CB_dina_vld || nl_din_vld) && out_rdy) begin
                out_cyc.push_back(cyc);
                chk("vld_exclusive", 64'(CB_dina_vld & nl_din_vld), 64'd0);
                chk("row_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("row_dest", 64'(nl_din_vld), 64'(e[DW]));
                    chk("row_data", cur, e[DW-1:0]);
                    chk("off_dest_data", other, 64'd0);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = (CB_dina_vld || nl_din_vld) && !out_rdy;
            prev_data  = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_job(input logic [2:0] s, input logic lk,
                             input logic [TB_AW-1:0] b, input logic [TB_AW-1:0] n);
        done_base     = done_cnt;
        enb_cyc.delete();
        out_cyc.delete();
        nl_vld_cycles = 0;
        cb_vld_cycles = 0;
        TB_douta_sel  = s;
        l_k_0         = lk;
        base_addr     = b;
        row_num       = n;
        start         = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == done_base && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 64'(done_cnt - done_base), 64'd1);
    endtask

    task automatic push_rows(input logic dest, input logic [TB_AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(b + TB_AW'(i));
            exp_q.push_back({dest, mem[b + TB_AW'(i)]});
        end
    endtask

    initial begin : stim
        int k;
        sys_rst_n = 1'b0; start = 1'b0; TB_douta_sel = '0; l_k_0 = 1'b0;
        base_addr = '0; row_num = '0; out_rdy = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {4{16'(i)}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_TB_enb", 64'(TB_enb), 64'd0);
        chk("rst_TB_addrb", 64'(TB_addrb), 64'd0);
        chk("rst_CB_dina", CB_dina, 64'd0);
        chk("rst_CB_vld", 64'(CB_dina_vld), 64'd0);
        chk("rst_nl_din", nl_din, 64'd0);
        chk("rst_nl_vld", 64'(nl_din_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        sys_rst_n = 1'b1;
        @(posedge clk); #1;

        // POS to CB, timing of addresses, rows and done
        push_rows(1'b0, 8'h10, 3);
        out_rdy = 1'b1;
        start_job(3'b001, 1'b0, 8'h10, 8'd3);
        chk("pos_busy", 64'(busy), 64'd1);
        wait_done("pos_done", 40);
        chk("pos_enb_count", 64'(enb_cyc.size()), 64'd3);
        chk("pos_first_enb", 64'(enb_cyc[0]), 64'(start_cyc + 1));
        chk("pos_enb_b2b", 64'(enb_cyc[2] - enb_cyc[0]), 64'd2);
        chk("pos_first_row", 64'(out_cyc[0]), 64'(enb_cyc[0] + RD_LAT + 1));
        chk("pos_row_b2b", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
        chk("pos_done_cyc", 64'(done_cyc), 64'(out_cyc[2] + 1));
        chk("pos_nl_quiet", 64'(nl_vld_cycles), 64'd0);
        chk("pos_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef TB_DOUTA_RD_CNT_EN
        chk("pos_rd_cnt", 64'(rd_cnt), 64'd3);
`endif

        // NEG to non-linear
        mem[8'h20] = {16'd4, 16'd3, 16'd2, 16'd1};
        exp_addr_q.push_back(8'h20);
        exp_q.push_back({1'b1, 16'd1, 16'd2, 16'd3, 16'd4});
        start_job(3'b110, 1'b0, 8'h20, 8'd1);
        wait_done("neg_done", 40);
        chk("neg_cb_quiet", 64'(cb_vld_cycles), 64'd0);
        chk("neg_rows", 64'(out_cyc.size()), 64'd1);

        // NEW, both halves
        mem[8'h30] = {16'd4, 16'd3, 16'd2, 16'd1};
        exp_addr_q.push_back(8'h30);
        exp_q.push_back({1'b0, 16'd0, 16'd0, 16'd2, 16'd1});
        start_job(3'b011, 1'b1, 8'h30, 8'd1);
        wait_done("new_lk1_done", 40);
        exp_addr_q.push_back(8'h30);
        exp_q.push_back({1'b0, 16'd0, 16'd0, 16'd4, 16'd3});
        start_job(3'b011, 1'b0, 8'h30, 8'd1);
        wait_done("new_lk0_done", 40);
        chk("new_rows", 64'(out_cyc.size()), 64'd1);

        // Backpressure: stall fully, then toggle ready 1,0,0,...
        push_rows(1'b0, 8'h40, 8);
        out_rdy = 1'b0;
        start_job(3'b001, 1'b0, 8'h40, 8'd8);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_credit_stall", 64'(enb_cyc.size()), 64'(FIFO_DEPTH + 1));
        chk("bp_busy", 64'(busy), 64'd1);
        k = 0;
        while (done_cnt == done_base && k < 300) begin
            out_rdy = (k % 3 == 0);
            @(posedge clk); #1;
            k++;
        end
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_done", 64'(done_cnt - done_base), 64'd1);
        chk("bp_rows", 64'(out_cyc.size()), 64'd8);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_addr_empty", 64'(exp_addr_q.size()), 64'd0);

        // row_num = 0
        start_job(3'b001, 1'b0, 8'h70, 8'd0);
        wait_done("zero_done", 10);
        chk("zero_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));
        chk("zero_no_enb", 64'(enb_cyc.size()), 64'd0);

        // Address wrap, plus a second start while busy
        push_rows(1'b0, 8'hFE, 3);
        start_job(3'b001, 1'b0, 8'hFE, 8'd3);
        TB_douta_sel = 3'b110; base_addr = 8'h80; row_num = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("wrap_done", 40);
        chk("wrap_enb_count", 64'(enb_cyc.size()), 64'd3);
        chk("wrap_rows", 64'(out_cyc.size()), 64'd3);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-ISSUE
        push_rows(1'b0, 8'h50, 8);
        start_job(3'b001, 1'b0, 8'h50, 8'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_vld", 64'(CB_dina_vld), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_TB_enb", 64'(TB_enb), 64'd0);
        chk("mid_rst_TB_addrb", 64'(TB_addrb), 64'd0);
        chk("mid_rst_CB_dina", CB_dina, 64'd0);
        chk("mid_rst_CB_vld", 64'(CB_dina_vld), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("mid_rst_no_done", 64'(done), 64'd0);
        end
`ifdef TB_DOUTA_RD_CNT_EN
        chk("mid_rst_rd_cnt", 64'(rd_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        exp_addr_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        push_rows(1'b0, 8'h60, 2);
        start_job(3'b001, 1'b0, 8'h60, 8'd2);
        wait_done("post_rst_done", 40);
        chk("post_rst_rows", 64'(out_cyc.size()), 64'd2);
        chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
